// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter that tracks the remaining cycles of an outstanding memory read.
module mem_latency_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    // done marks the cycle whose decrement takes the count to zero
    assign count = r_count;
    assign done  = (r_count == W'(1));

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-port memory between the fetch path and the load/store path,
// with data priority, a fetch starvation guard and fixed-latency read return routing.
module memory_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  pc_stall
);

    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t       r_state, w_state_next;
    owner_t           r_owner, w_owner_next;
    logic [STV_W-1:0] r_starve, w_starve_next;
    logic [LAT_W-1:0] w_lat_count;
    logic             w_lat_done;
    logic             w_lat_load;
    logic             w_ret;
    logic             w_opp;
    logic             w_if_wins;
    logic             w_if_gnt;
    logic             w_d_gnt;

    mem_latency_counter #(
        .W(LAT_W)
    ) u_lat (
        .clk   (clk),
        .reset (reset),
        .load  (w_lat_load),
        .value (LAT_W'(MEM_LATENCY)),
        .count (w_lat_count),
        .done  (w_lat_done)
    );

    assign w_ret     = (r_state == ARB_WAIT) && w_lat_done;
    assign w_opp     = (r_state == ARB_IDLE) || w_ret;
    assign w_if_wins = if_req && (!d_req || (r_starve == STV_W'(STARVE_LIMIT)));
    // Everything is gated by reset so a held-low reset silences all outputs.
    assign w_if_gnt  = reset && w_opp && w_if_wins;
    assign w_d_gnt   = reset && w_opp && d_req && !w_if_wins;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ARB_IDLE;
            r_owner  <= OWN_IF;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_next;
            r_owner  <= w_owner_next;
            r_starve <= w_starve_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_owner_next  = r_owner;
        w_starve_next = r_starve;
        w_lat_load    = 1'b0;
        if_gnt        = w_if_gnt;
        d_gnt         = w_d_gnt;
        if_rvalid     = 1'b0;
        d_rvalid      = 1'b0;
        if_rdata      = '0;
        d_rdata       = '0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        pc_stall      = 1'b0;

        if (reset) begin
            if (w_opp) begin
                mem_en = w_if_gnt || w_d_gnt;
                if (w_if_gnt) begin
                    mem_addr = if_addr;
                end else if (w_d_gnt) begin
                    mem_we    = d_we;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                end

                if (w_if_gnt || !if_req) begin
                    w_starve_next = '0;
                end else if (r_starve != STV_W'(STARVE_LIMIT)) begin
                    w_starve_next = r_starve + 1'b1;
                end

                if (w_if_gnt || (w_d_gnt && !d_we)) begin
                    w_state_next = ARB_WAIT;
                    w_lat_load   = 1'b1;
                    w_owner_next = w_if_gnt ? OWN_IF : OWN_D;
                end else begin
                    w_state_next = ARB_IDLE;
                end
            end else if (w_lat_count == '0) begin
                w_state_next = ARB_IDLE;
            end

            if_rvalid = w_ret && (r_owner == OWN_IF);
            d_rvalid  = w_ret && (r_owner == OWN_D);
            if_rdata  = mem_rdata;
            d_rdata   = mem_rdata;
            pc_stall  = (if_req && !w_if_gnt) ||
                        ((r_state == ARB_WAIT) && (r_owner == OWN_IF) && !w_ret);
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: a cycle-level reference model plus pinned scenario values.
module tb_memory_port_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int SL  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          pc_stall;

    always #5 clk = ~clk;

    memory_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MEM_LATENCY  (LAT),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pc_stall  (pc_stall)
    );

    // Single-port memory with a two-cycle read pipeline and a default content pattern.
    logic [DW-1:0] mem_arr [1<<AW];
    logic          mem_wr  [1<<AW];
    logic [DW-1:0] rd_pipe0 = '0;
    logic [DW-1:0] rd_pipe1 = '0;

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem_wr[a] === 1'b1) return mem_arr[a];
        if (a == 10'h010) return 32'h00500093;
        return 32'hA5A50000 | DW'(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_arr[mem_addr] <= mem_wdata;
            mem_wr[mem_addr]  <= 1'b1;
        end
        rd_pipe0 <= (mem_en && !mem_we) ? mem_read(mem_addr) : 32'hBAD0BAD0;
        rd_pipe1 <= rd_pipe0;
    end
    assign mem_rdata = rd_pipe1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: cycle the outstanding read returns, its owner and data.
    int            ret_cyc  = -1;
    bit            own_if   = 1'b1;
    logic [DW-1:0] ret_data = '0;
    int            starve   = 0;
    bit            hold_d   = 1'b0;

    logic          s_if_gnt, s_d_gnt, s_if_rvalid, s_d_rvalid;
    logic          s_mem_en, s_mem_we, s_pc_stall;
    logic [AW-1:0] s_mem_addr;
    logic [DW-1:0] s_if_rdata, s_d_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit pending, ret, opp, ifw, e_ifg, e_dg, e_stall;
        s_if_gnt    = if_gnt;
        s_d_gnt     = d_gnt;
        s_if_rvalid = if_rvalid;
        s_d_rvalid  = d_rvalid;
        s_mem_en    = mem_en;
        s_mem_we    = mem_we;
        s_pc_stall  = pc_stall;
        s_mem_addr  = mem_addr;
        s_if_rdata  = if_rdata;
        s_d_rdata   = d_rdata;

        if (!reset) begin
            chk("rst_if_gnt",    s_if_gnt,    0);
            chk("rst_d_gnt",     s_d_gnt,     0);
            chk("rst_if_rvalid", s_if_rvalid, 0);
            chk("rst_d_rvalid",  s_d_rvalid,  0);
            chk("rst_mem_en",    s_mem_en,    0);
            chk("rst_mem_we",    s_mem_we,    0);
            chk("rst_pc_stall",  s_pc_stall,  0);
            ret_cyc = -1;
            starve  = 0;
            own_if  = 1'b1;
            return;
        end

        pending = (ret_cyc >= cyc);
        ret     = (ret_cyc == cyc);
        opp     = !pending || ret;
        ifw     = if_req && (!d_req || starve == SL);
        e_ifg   = opp && ifw;
        e_dg    = opp && d_req && !ifw;
        e_stall = (if_req && !e_ifg) || (pending && !ret && own_if);

        chk("if_gnt",    s_if_gnt,    e_ifg);
        chk("d_gnt",     s_d_gnt,     e_dg);
        chk("mem_en",    s_mem_en,    e_ifg || e_dg);
        chk("mem_we",    s_mem_we,    e_dg && d_we);
        chk("if_rvalid", s_if_rvalid, ret && own_if);
        chk("d_rvalid",  s_d_rvalid,  ret && !own_if);
        chk("pc_stall",  s_pc_stall,  e_stall);
        if (ret && own_if)  chk("if_rdata", s_if_rdata, ret_data);
        if (ret && !own_if) chk("d_rdata",  s_d_rdata,  ret_data);
        if (e_ifg) chk("mem_addr_if", s_mem_addr, if_addr);
        if (e_dg)  chk("mem_addr_d",  s_mem_addr, d_addr);
        if (e_dg && d_we) chk("mem_wdata", mem_wdata, d_wdata);

        if (opp) begin
            if (e_ifg || !if_req) starve = 0;
            else if (starve < SL) starve++;
            if (e_ifg || (e_dg && !d_we)) begin
                ret_cyc  = cyc + LAT;
                own_if   = e_ifg;
                ret_data = mem_read(e_ifg ? if_addr : d_addr);
            end
        end
    endtask

    // One clock: check at the falling edge, then let requesters drop granted requests.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (s_if_gnt) if_req = 1'b0;
        if (s_d_gnt && !hold_d) d_req = 1'b0;
    endtask

    initial begin
        int dg;
        bit got;
        reset   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Idle fetch
        if_req = 1'b1; if_addr = 10'h010;
        tick();
        chk("s1_if_gnt",   s_if_gnt, 1);
        chk("s1_mem_addr", s_mem_addr, 10'h010);
        tick();
        tick();
        chk("s1_if_rvalid", s_if_rvalid, 1);
        chk("s1_if_rdata",  s_if_rdata, 32'h00500093);

        // Collision: data wins, fetch granted on the return cycle
        if_req = 1'b1; if_addr = 10'h011;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h100;
        tick();
        chk("s2_d_gnt",    s_d_gnt, 1);
        chk("s2_if_gnt",   s_if_gnt, 0);
        chk("s2_pc_stall", s_pc_stall, 1);
        tick();
        tick();
        chk("s2_d_rvalid", s_d_rvalid, 1);
        chk("s2_d_rdata",  s_d_rdata, 32'hA5A50100);
        chk("s2_if_gnt2",  s_if_gnt, 1);
        tick();
        tick();

        // Write then fetch, then read the written word back
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h080; d_wdata = 32'hDEADBEEF;
        tick();
        chk("s3_d_gnt",    s_d_gnt, 1);
        chk("s3_mem_we",   s_mem_we, 1);
        chk("s3_d_rvalid", s_d_rvalid, 0);
        d_we = 1'b0;
        if_req = 1'b1; if_addr = 10'h012;
        tick();
        chk("s3_if_gnt", s_if_gnt, 1);
        tick();
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h080;
        tick();
        tick();
        tick();
        chk("s3_rb_rvalid", s_d_rvalid, 1);
        chk("s3_rb_rdata",  s_d_rdata, 32'hDEADBEEF);

        // Starvation: continuous data reads against a held fetch
        hold_d = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h040;
        if_req = 1'b1; if_addr = 10'h020;
        dg = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (s_if_gnt) got = 1'b1;
            else if (s_d_gnt) dg++;
        end
        chk("s4_if_won", got, 1);
        chk("s4_d_wins", dg, 4);
        hold_d = 1'b0;
        tick();
        tick();
        chk("s4_d_after", s_d_gnt, 1);
        repeat (4) tick();

        // Reset during an outstanding fetch
        if_req = 1'b1; if_addr = 10'h030;
        tick();
        chk("s5_if_gnt", s_if_gnt, 1);
        reset = 1'b0;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 10'h000;
        tick();
        chk("s5_rst_if_gnt", s_if_gnt, 0);
        chk("s5_rst_d_gnt",  s_d_gnt, 0);
        chk("s5_rst_mem_en", s_mem_en, 0);
        chk("s5_rst_stall",  s_pc_stall, 0);
        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("s5_no_rvalid", s_if_rvalid, 0);
        tick();

        // Fetch request withdrawn while a data read is outstanding
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h050;
        tick();
        if_req = 1'b1; if_addr = 10'h060;
        tick();
        chk("s6_if_gnt_wait", s_if_gnt, 0);
        chk("s6_stall_wait",  s_pc_stall, 1);
        if_req = 1'b0;
        tick();
        chk("s6_if_gnt_ret", s_if_gnt, 0);
        chk("s6_stall_ret",  s_pc_stall, 0);
        chk("s6_d_rvalid",   s_d_rvalid, 1);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
